// File: rtl/ext_device_buffer.sv
// Sample buffer that fills 12 words, interrupts the CPU, then serves 4-word blocks to the DMA while granted.
// Optional build macro DEVBUF_OVF_CNT_EN adds a saturating dropped-sample counter on ovf_cnt.
//
//  state | meaning
//  FILL  | accepting samples into mem[wr_ptr]
//  READY | buffer full, waiting for bus grant
//  XFER  | DMA owns the bus, waiting for grant release
module ext_device_buffer #(
   parameter int WORD_SIZE   = 16,
   parameter int BLOCK_WORDS = 4,
   parameter int NUM_BLOCKS  = 3
) (
   input  logic                           CLK,
   input  logic                           reset_n,
   input  logic                           in_valid,
   input  logic [WORD_SIZE-1:0]           in_data,
   output logic                           in_ready,
   input  logic                           BG,
   input  logic [1:0]                     offset,
   output logic [BLOCK_WORDS*WORD_SIZE-1:0] edata,
   output logic                           dev_intr,
   output logic                           done,
   output logic [7:0]                     ovf_cnt
);

   localparam int         DEPTH = BLOCK_WORDS * NUM_BLOCKS;
   localparam logic [3:0] LAST  = 4'(DEPTH - 1);

   typedef enum logic [1:0] {
      FILL  = 2'd0,
      READY = 2'd1,
      XFER  = 2'd2
   } state_t;

   state_t               state;
   logic [3:0]           wr_ptr;
   logic                 bg_q;
   logic [WORD_SIZE-1:0] mem [DEPTH];

   assign in_ready = (state == FILL);

   always_ff @(posedge CLK or negedge reset_n) begin
      if (!reset_n) begin
         state    <= FILL;
         wr_ptr   <= 4'd0;
         bg_q     <= 1'b0;
         dev_intr <= 1'b0;
         done     <= 1'b0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
         dev_intr <= 1'b0;
         done     <= 1'b0;
         bg_q     <= BG;
         case (state)
            FILL: begin
               if (in_valid) begin
                  mem[wr_ptr] <= in_data;
                  if (wr_ptr == LAST) begin
                     wr_ptr   <= 4'd0;
                     state    <= READY;
                     dev_intr <= 1'b1;
                  end else begin
                     wr_ptr <= wr_ptr + 4'd1;
                  end
               end
            end
            READY: begin
               if (BG) state <= XFER;
            end
            XFER: begin
               // Release is a falling edge of grant seen while in XFER.
               if (bg_q && !BG) begin
                  state <= FILL;
                  done  <= 1'b1;
               end
            end
            default: state <= FILL;
         endcase
      end
   end

   // Offset 2'b11 means no block is selected and reads as zero.
   always_comb begin
      logic [3:0] idx;
      edata = '0;
      idx   = 4'd0;
      if (offset != 2'b11) begin
         for (int k = 0; k < BLOCK_WORDS; k++) begin
            idx = 4'(BLOCK_WORDS * int'(offset) + k);
            edata[k*WORD_SIZE +: WORD_SIZE] = mem[idx];
         end
      end
   end

`ifdef DEVBUF_OVF_CNT_EN
   always_ff @(posedge CLK or negedge reset_n) begin
      if (!reset_n) begin
         ovf_cnt <= 8'h00;
      end else if (in_valid && !in_ready && ovf_cnt != 8'hFF) begin
         ovf_cnt <= ovf_cnt + 8'h01;
      end
   end
`else
   assign ovf_cnt = 8'h00;
`endif

endmodule

// File: tb/tb_ext_device_buffer.sv
// Directed bench for ext_device_buffer: fill/interrupt, block readout, re-arm, overflow, reset and grant-in-fill cases.
module tb_ext_device_buffer;

   logic        CLK = 1'b0;
   logic        reset_n;
   logic        in_valid;
   logic [15:0] in_data;
   logic        in_ready;
   logic        BG;
   logic [1:0]  offset;
   logic [63:0] edata;
   logic        dev_intr;
   logic        done;
   logic [7:0]  ovf_cnt;

   int total = 0;
   int bad   = 0;
   int n_intr = 0;
   int n_done = 0;

   logic [63:0] sb [$];
   logic [15:0] mbuf [12];
   int          mptr = 0;

`ifdef DEVBUF_OVF_CNT_EN
   localparam logic [7:0] OVF_FULL = 8'hFF;
`else
   localparam logic [7:0] OVF_FULL = 8'h00;
`endif

   ext_device_buffer dut (
      .CLK      (CLK),
      .reset_n  (reset_n),
      .in_valid (in_valid),
      .in_data  (in_data),
      .in_ready (in_ready),
      .BG       (BG),
      .offset   (offset),
      .edata    (edata),
      .dev_intr (dev_intr),
      .done     (done),
      .ovf_cnt  (ovf_cnt)
   );

   always #5 CLK = ~CLK;

   initial begin
      #2000000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
      if (dev_intr === 1'b1) n_intr++;
      if (done === 1'b1) n_done++;
      chk("intr_done_excl", {63'b0, dev_intr & done}, 64'h0);
   endtask

   function automatic logic [63:0] blk(input logic [1:0] off);
      if (off == 2'b11) return 64'h0;
      return {mbuf[4*off+3], mbuf[4*off+2], mbuf[4*off+1], mbuf[4*off]};
   endfunction

   // Expected block is pushed as the offset is driven, then popped against edata.
   task automatic sel(input string tag, input logic [1:0] off, input logic [63:0] exp);
      sb.push_back(exp);
      offset = off;
      #1;
      chk(tag, edata, sb.pop_front());
   endtask

   task automatic fill(input logic [15:0] base, input int n, input bit bg_pulse);
      for (int i = 0; i < n; i++) begin
         in_valid = 1'b1;
         in_data  = base + 16'(i);
         BG       = bg_pulse & i[0];
         chk("in_ready_fill", {63'b0, in_ready}, 64'h1);
         mbuf[mptr] = in_data;
         mptr = (mptr + 1) % 12;
         tick();
      end
      in_valid = 1'b0;
      BG       = 1'b0;
   endtask

   initial begin
      reset_n  = 1'b0;
      in_valid = 1'b0;
      in_data  = 16'h0;
      BG       = 1'b0;
      offset   = 2'b11;
      for (int i = 0; i < 12; i++) mbuf[i] = 16'h0;
      repeat (2) @(posedge CLK);
      #1;
      reset_n = 1'b1;

      chk("rst_in_ready", {63'b0, in_ready}, 64'h1);
      chk("rst_dev_intr", {63'b0, dev_intr}, 64'h0);
      chk("rst_done", {63'b0, done}, 64'h0);
      chk("rst_ovf", {56'b0, ovf_cnt}, 64'h0);
      sel("rst_edata0", 2'd0, 64'h0);

      // 1: twelve samples, one interrupt
      n_intr = 0;
      fill(16'h0001, 12, 1'b0);
      chk("t1_in_ready_low", {63'b0, in_ready}, 64'h0);
      chk("t1_dev_intr_hi", {63'b0, dev_intr}, 64'h1);
      tick();
      chk("t1_dev_intr_lo", {63'b0, dev_intr}, 64'h0);
      chk("t1_intr_count", 64'(n_intr), 64'd1);
      chk("t1_ovf", {56'b0, ovf_cnt}, 64'h0);

      // 2: grant, then step offsets
      BG = 1'b1;
      tick();
      sel("t2_off3", 2'd3, 64'h0);
      sel("t2_off0", 2'd0, 64'h0004_0003_0002_0001);
      sel("t2_off1", 2'd1, 64'h0008_0007_0006_0005);
      sel("t2_off2", 2'd2, 64'h000C_000B_000A_0009);

      // 3: release grant, re-arm, refill overwrites word 0 first
      n_done = 0;
      BG = 1'b0;
      tick();
      chk("t3_done_hi", {63'b0, done}, 64'h1);
      chk("t3_in_ready", {63'b0, in_ready}, 64'h1);
      tick();
      chk("t3_done_lo", {63'b0, done}, 64'h0);
      chk("t3_done_count", 64'(n_done), 64'd1);
      fill(16'hA000, 1, 1'b0);
      sel("t3_refill_lit", 2'd0, 64'h0004_0003_0002_A000);
      sel("t3_refill_mdl", 2'd1, blk(2'd1));
      n_intr = 0;
      fill(16'hA001, 11, 1'b0);
      chk("t3_dev_intr", {63'b0, dev_intr}, 64'h1);

      // 4: offered samples while not ready are dropped
      in_valid = 1'b1;
      in_data  = 16'hFFFF;
      repeat (300) tick();
      in_valid = 1'b0;
      chk("t4_ovf", {56'b0, ovf_cnt}, {56'b0, OVF_FULL});
      chk("t4_intr_count", 64'(n_intr), 64'd1);
      sel("t4_keep0", 2'd0, blk(2'd0));
      sel("t4_keep2", 2'd2, 64'hA00B_A00A_A009_A008);
      BG = 1'b1;
      tick();
      chk("t4_xfer_in_ready", {63'b0, in_ready}, 64'h0);
      BG = 1'b0;
      tick();
      chk("t4_done", {63'b0, done}, 64'h1);

      // 6: grant pulses during fill are ignored
      n_intr = 0;
      n_done = 0;
      fill(16'h5000, 11, 1'b1);
      chk("t6_no_intr", 64'(n_intr), 64'd0);
      chk("t6_no_done", 64'(n_done), 64'd0);
      fill(16'h500B, 1, 1'b0);
      chk("t6_dev_intr", {63'b0, dev_intr}, 64'h1);
      sel("t6_blk1", 2'd1, blk(2'd1));

      // 5: async reset after 5 samples
      BG = 1'b1;
      tick();
      BG = 1'b0;
      tick();
      chk("t5_done", {63'b0, done}, 64'h1);
      fill(16'hC000, 5, 1'b0);
      sel("t5_pre_rst", 2'd1, blk(2'd1));
      reset_n = 1'b0;
      #1;
      for (int i = 0; i < 12; i++) mbuf[i] = 16'h0;
      mptr = 0;
      sel("t5_rst_edata0", 2'd0, 64'h0);
      sel("t5_rst_edata1", 2'd1, 64'h0);
      chk("t5_rst_in_ready", {63'b0, in_ready}, 64'h1);
      chk("t5_rst_intr", {63'b0, dev_intr}, 64'h0);
      chk("t5_rst_done", {63'b0, done}, 64'h0);
      chk("t5_rst_ovf", {56'b0, ovf_cnt}, 64'h0);
      tick();
      reset_n = 1'b1;
      n_intr = 0;
      n_done = 0;
      fill(16'hD000, 12, 1'b0);
      chk("t5_dev_intr", {63'b0, dev_intr}, 64'h1);
      sel("t5_blk0", 2'd0, 64'hD003_D002_D001_D000);
      sel("t5_blk2", 2'd2, blk(2'd2));
      tick();
      chk("t5_intr_count", 64'(n_intr), 64'd1);
      chk("t5_no_done", 64'(n_done), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
